// File: rtl/buffer_link_arbiter.sv
// Round-robin arbiter/sequencer for the shared 3-bit link between two buffer stations.
// Optional per-station transfer counters are built only when LINK_STATS_EN is defined.
//
// state  | meaning
// IDLE   | link free, waiting for a request
// XFER   | link granted to winner, hold counter running
// DONE   | one-cycle delivery strobe, link released
// BAD    | unreachable code, recovers to IDLE
module buffer_link_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [2:0]       data0,
  input  logic [2:0]       data1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             xfer_valid,
  output logic             xfer_dst,
  output logic [2:0]       xfer_data,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stat0,
  output logic [CNT_W-1:0] stat1
);

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2,
    S_BAD  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            winner_q;
  logic            last_q;
  logic [HC_W-1:0] hold_q;
  logic [2:0]      pkt_q;
  logic            dst_q;
  logic [2:0]      data_q;
  logic            pick;
  logic            grant_go;
  logic            done_go;

  // Sole requester wins; on a tie the station not served last wins.
  assign pick = (req == 2'b01) ? 1'b0 :
                (req == 2'b10) ? 1'b1 : ~last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    grant_go = 1'b0;
    done_go  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          state_d  = S_XFER;
          grant_go = 1'b1;
        end
      end
      S_XFER: begin
        if (!req[winner_q]) begin
          state_d = S_IDLE;
        end else if (hold_q == '0) begin
          state_d = S_DONE;
          done_go = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      winner_q <= 1'b0;
      last_q   <= 1'b1;
      hold_q   <= '0;
      pkt_q    <= 3'b000;
      dst_q    <= 1'b0;
      data_q   <= 3'b000;
    end else begin
      if (grant_go) begin
        winner_q <= pick;
        pkt_q    <= pick ? data1 : data0;
        hold_q   <= HOLD_LOAD;
      end else if (state_q == S_XFER && hold_q != '0) begin
        hold_q <= hold_q - HC_W'(1);
      end
      if (done_go) begin
        last_q <= winner_q;
        dst_q  <= ~winner_q;
        data_q <= pkt_q;
      end
    end
  end

  assign gnt        = (state_q == S_XFER) ? (winner_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy       = (state_q == S_XFER) || (state_q == S_DONE);
  assign xfer_valid = (state_q == S_DONE);
  assign xfer_dst   = dst_q;
  assign xfer_data  = data_q;
  assign state      = state_q;

`ifdef LINK_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  // Saturating counters, bumped as the transfer commits to DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (done_go) begin
      if (!winner_q && cnt0_q != '1) cnt0_q <= cnt0_q + CNT_W'(1);
      if (winner_q && cnt1_q != '1)  cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign stat0 = cnt0_q;
  assign stat1 = cnt1_q;
`else
  assign stat0 = '0;
  assign stat1 = '0;
`endif

endmodule

// File: tb/tb_buffer_link_arbiter.sv
// Self-checking bench for buffer_link_arbiter: directed scenarios plus random
// request/data traffic compared against a transaction-timing reference model.
module tb_buffer_link_arbiter;
  localparam int HOLD = 4;
  localparam int CW   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req = 2'b00;
  logic [2:0]    data0 = 3'b000;
  logic [2:0]    data1 = 3'b000;
  logic [1:0]    gnt;
  logic          busy;
  logic          xfer_valid;
  logic          xfer_dst;
  logic [2:0]    xfer_data;
  logic [1:0]    state;
  logic [CW-1:0] stat0;
  logic [CW-1:0] stat1;

  buffer_link_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
    .gnt(gnt), .busy(busy), .xfer_valid(xfer_valid), .xfer_dst(xfer_dst),
    .xfer_data(xfer_data), .state(state), .stat0(stat0), .stat1(stat1)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // Reference model: a transfer is described by its grant edge t0 and owner;
  // it completes at edge t0+HOLD unless the owner's request is seen low first.
  bit       m_active;
  int       m_t0;
  bit       m_w;
  bit [2:0] m_pkt;
  bit       m_last;
  int       m_edge;
  int       m_valid_e;
  bit       m_dst;
  bit [2:0] m_data;
  int       m_s0, m_s1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int stat_exp(input int n);
    int mx;
    mx = (1 << CW) - 1;
`ifdef LINK_STATS_EN
    return (n > mx) ? mx : n;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_active  = 1'b0;
    m_last    = 1'b1;
    m_edge    = 0;
    m_valid_e = -10;
    m_dst     = 1'b0;
    m_data    = 3'b000;
    m_s0      = 0;
    m_s1      = 0;
  endtask

  task automatic model_edge();
    m_edge++;
    if (m_active) begin
      if (!req[m_w]) begin
        m_active = 1'b0;
      end else if (m_edge - m_t0 == HOLD) begin
        m_active  = 1'b0;
        m_valid_e = m_edge;
        m_dst     = ~m_w;
        m_data    = m_pkt;
        m_last    = m_w;
        if (m_w) m_s1++;
        else     m_s0++;
      end
    end else if (m_edge != m_valid_e + 1 && req != 2'b00) begin
      m_w      = (req == 2'b11) ? ~m_last : req[1];
      m_pkt    = m_w ? data1 : data0;
      m_t0     = m_edge;
      m_active = 1'b1;
    end
  endtask

  task automatic check_outs(input string tag);
    logic [1:0] e_gnt;
    logic       e_val;
    logic [1:0] e_state;
    e_gnt   = m_active ? (m_w ? 2'b10 : 2'b01) : 2'b00;
    e_val   = (m_edge == m_valid_e);
    e_state = m_active ? 2'd1 : (e_val ? 2'd2 : 2'd0);
    chk({tag, "_gnt"},   32'(gnt),        32'(e_gnt));
    chk({tag, "_valid"}, 32'(xfer_valid), 32'(e_val));
    chk({tag, "_state"}, 32'(state),      32'(e_state));
    chk({tag, "_busy"},  32'(busy),       32'(m_active | e_val));
    chk({tag, "_dst"},   32'(xfer_dst),   32'(m_dst));
    chk({tag, "_data"},  32'(xfer_data),  32'(m_data));
    chk({tag, "_stat0"}, 32'(stat0),      32'(stat_exp(m_s0)));
    chk({tag, "_stat1"}, 32'(stat1),      32'(stat_exp(m_s1)));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outs(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check_outs(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // 1: asynchronous reset before any clock edge
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_outs("rst_async");
    @(negedge clk);
    rst = 1'b1;

    // 2: single request from station 0, data changes after grant are ignored
    data0 = 3'b101;
    req   = 2'b01;
    step("t2_grant");
    chk("t2_gnt01", 32'(gnt), 32'd1);
    data0 = 3'b010;
    run("t2_hold", HOLD - 1);
    step("t2_deliver");
    chk("t2_strobe", 32'(xfer_valid), 32'd1);
    chk("t2_dst1",   32'(xfer_dst),   32'd1);
    chk("t2_pkt",    32'(xfer_data),  32'd5);
    req = 2'b00;
    step("t2_idle");
    chk("t2_state0", 32'(state), 32'd0);

    // 3: both stations request continuously from reset
    do_reset("t3_rst");
    data0 = 3'b011;
    data1 = 3'b110;
    req   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step("t3_grant");
      chk("t3_alt_gnt", 32'(gnt), (k % 2 == 0) ? 32'd1 : 32'd2);
      run("t3_hold", HOLD - 1);
      step("t3_deliver");
      chk("t3_alt_dst", 32'(xfer_dst), (k % 2 == 0) ? 32'd1 : 32'd0);
      step("t3_release");
    end
    req = 2'b00;
    run("t3_drain", HOLD + 2);

    // 4: abort on the second XFER cycle leaves the pointer untouched
    do_reset("t4_rst");
    req = 2'b01;
    step("t4_grant");
    step("t4_xfer1");
    req = 2'b00;
    step("t4_abort");
    chk("t4_abort_state", 32'(state), 32'd0);
    chk("t4_abort_valid", 32'(xfer_valid), 32'd0);
    req = 2'b11;
    step("t4_regrant");
    chk("t4_ptr_keep", 32'(gnt), 32'd1);
    run("t4_finish", HOLD + 1);
    req = 2'b00;
    run("t4_drain", HOLD + 2);

    // 5: reset during a transfer owned by station 1
    req = 2'b10;
    step("t5_grant");
    step("t5_xfer");
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_outs("t5_rst_mid");
    chk("t5_gnt_clear", 32'(gnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step("t5_regrant");
    chk("t5_gnt10", 32'(gnt), 32'd2);
    req = 2'b00;
    run("t5_drain", HOLD + 2);

    // 6: five completed transfers from station 0 saturate its counter
    do_reset("t6_rst");
    req = 2'b01;
    run("t6_xfers", 5 * (HOLD + 2));
    req = 2'b00;
    run("t6_drain", 2);
`ifdef LINK_STATS_EN
    chk("t6_stat0_sat", 32'(stat0), 32'd3);
`else
    chk("t6_stat0_off", 32'(stat0), 32'd0);
`endif
    chk("t6_stat1", 32'(stat1), 32'd0);

    // Random traffic: requests mostly held, occasional drops cause aborts
    do_reset("rnd_rst");
    for (int i = 0; i < 600; i++) begin
      data0 = 3'($urandom);
      data1 = 3'($urandom);
      for (int b = 0; b < 2; b++) begin
        if (req[b]) begin
          if ($urandom_range(0, 15) == 0) req[b] = 1'b0;
        end else begin
          if ($urandom_range(0, 3) == 0) req[b] = 1'b1;
        end
      end
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
